// File: rtl/lfsr_ks_pkg.sv
// lfsr_ks_pkg: shared types and constants for the LFSR keystream controller.
// Holds the FSM state enum, the LFSR and byte widths, and the default warm-up length.
package lfsr_ks_pkg;

  localparam int LFSR_W         = 80;
  localparam int BYTE_W         = 8;
  localparam int WARMUP_DEFAULT = 160;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WARMUP,
    GATHER,
    HOLD
  } ks_state_t;

endpackage

// File: rtl/lfsr_ks_ctrl_lfsr.sv
// lfsr: 80-bit Fibonacci LFSR with parallel load, right shift, bit 0 is the serial output.
// Ports: clk, rst (sync, high), shift_en, Par_load, Seed[79:0] in; Par_out[79:0] out.
module lfsr
  import lfsr_ks_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              Par_load,
  input  logic [LFSR_W-1:0] Seed,
  output logic [LFSR_W-1:0] Par_out
);

  logic [LFSR_W-1:0] r;
  logic              fb;

  // s[i+80] = s[i] ^ s[i+13] ^ s[i+23] ^ s[i+38] ^ s[i+51] ^ s[i+62]
  assign fb = r[0] ^ r[13] ^ r[23] ^ r[38] ^ r[51] ^ r[62];

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
    end else if (Par_load) begin
      r <= Seed;
    end else if (shift_en) begin
      r <= {fb, r[LFSR_W-1:1]};
    end
  end

  assign Par_out = r;

endmodule

// File: rtl/lfsr_ks_ctrl.sv
// lfsr_ks_ctrl: seeds an 80-bit LFSR, optionally discards WARMUP_CYCLES bits, then packs
// serial bits MSB-first into bytes offered on a valid/ready port; stop aborts to idle.
// Ports: clk, rst (sync, high), start, stop, seed[79:0], ks_ready in;
//        ks_data[7:0], ks_valid, busy, lfsr_state[79:0] out.
// Macro LFSR_KS_CTRL_WARMUP_EN builds the WARMUP state; otherwise LOAD goes to GATHER.
module lfsr_ks_ctrl
  import lfsr_ks_pkg::*;
#(
  parameter int WARMUP_CYCLES = WARMUP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [LFSR_W-1:0] seed,
  output logic [BYTE_W-1:0] ks_data,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic              busy,
  output logic [LFSR_W-1:0] lfsr_state
);

  if (WARMUP_CYCLES < 1) begin : g_bad_warmup
    $error("WARMUP_CYCLES must be at least 1");
  end

  ks_state_t         state;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_q;
  logic              shift_en;
  logic              par_load;
  logic              abort;

`ifdef LFSR_KS_CTRL_WARMUP_EN
  localparam int WCW = $clog2(WARMUP_CYCLES + 1);
  logic [WCW-1:0] warm_cnt;
`endif

  assign abort    = stop && (state != IDLE);
  assign par_load = (state == LOAD);
  // No shift on the abort edge, so an aborted run leaves the LFSR where it stopped.
  assign shift_en = ((state == WARMUP) || (state == GATHER)) && !abort;

  lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .shift_en(shift_en),
    .Par_load(par_load),
    .Seed    (seed),
    .Par_out (lfsr_state)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ks_valid <= 1'b0;
      busy     <= 1'b0;
      byte_q   <= '0;
      bit_cnt  <= '0;
`ifdef LFSR_KS_CTRL_WARMUP_EN
      warm_cnt <= '0;
`endif
    end else if (abort) begin
      state    <= IDLE;
      ks_valid <= 1'b0;
      busy     <= 1'b0;
      byte_q   <= '0;
      bit_cnt  <= '0;
`ifdef LFSR_KS_CTRL_WARMUP_EN
      warm_cnt <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
`ifdef LFSR_KS_CTRL_WARMUP_EN
          state    <= WARMUP;
          warm_cnt <= '0;
`else
          state   <= GATHER;
          bit_cnt <= '0;
`endif
        end
`ifdef LFSR_KS_CTRL_WARMUP_EN
        WARMUP: begin
          if (warm_cnt == WCW'(WARMUP_CYCLES - 1)) begin
            state   <= GATHER;
            bit_cnt <= '0;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
`endif
        GATHER: begin
          byte_q <= {byte_q[BYTE_W-2:0], lfsr_state[0]};
          if (bit_cnt == 3'd7) begin
            state    <= HOLD;
            ks_valid <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        HOLD: begin
          if (ks_ready) begin
            state    <= GATHER;
            ks_valid <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          ks_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign ks_data = byte_q;

endmodule

// File: tb/tb_lfsr_ks_ctrl.sv
// tb_lfsr_ks_ctrl: self-checking bench for lfsr_ks_ctrl against a bit-sequence model.
// Latencies count rising edges inclusively, starting with the edge that samples the request.
module tb_lfsr_ks_ctrl;

  localparam int W = 160;
`ifdef LFSR_KS_CTRL_WARMUP_EN
  localparam int WE = W;
`else
  localparam int WE = 0;
`endif
  localparam int NSEQ = 8192;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [79:0] seed;
  logic [7:0]  ks_data;
  logic        ks_valid;
  logic        ks_ready;
  logic        busy;
  logic [79:0] lfsr_state;

  lfsr_ks_ctrl #(.WARMUP_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .seed      (seed),
    .ks_data   (ks_data),
    .ks_valid  (ks_valid),
    .ks_ready  (ks_ready),
    .busy      (busy),
    .lfsr_state(lfsr_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- model: the serial bit stream s[i] generated from the seed ----
  bit seq [0:NSEQ-1];

  function automatic void gen(input logic [79:0] s);
    for (int i = 0; i < 80; i++) seq[i] = s[i];
    for (int i = 80; i < NSEQ; i++)
      seq[i] = seq[i-80] ^ seq[i-67] ^ seq[i-57] ^ seq[i-42] ^ seq[i-29] ^ seq[i-18];
  endfunction

  function automatic logic [7:0] mbyte(input int off);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[7-b] = seq[off+b];
    return r;
  endfunction

  bit         m_act, m_load, m_v, m_lk, m_zero, m_seeded;
  int         m_n;
  logic [7:0] m_d;

  function automatic logic [79:0] m_lfsr();
    logic [79:0] r;
    r = '0;
    if (m_seeded)
      for (int b = 0; b < 80; b++) r[b] = seq[m_n+b];
    return r;
  endfunction

  // Model update from the inputs seen at the edge, then compare just after it.
  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_load = 0; m_v = 0; m_d = '0;
      m_lk = 1; m_zero = 1; m_seeded = 0; m_n = 0;
    end else if (m_act && stop) begin
      m_act = 0; m_load = 0; m_v = 0; m_lk = 0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1; m_load = 1;
      end
    end else if (m_load) begin
      m_load = 0; gen(seed); m_seeded = 1;
      m_lk = 1; m_n = 0; m_zero = 0;
    end else if (m_v) begin
      if (ks_ready) m_v = 0;
    end else begin
      m_n++;
      if (m_n - WE >= 8 && (m_n - WE) % 8 == 0) begin
        m_v = 1;
        m_d = mbyte(m_n - 8);
      end
    end
    #1;
    if (chk_en) begin
      chk("valid", ks_valid, m_v);
      chk("busy", busy, m_act);
      if (m_v) chk("data", ks_data, m_d);
      if (m_zero) chk("data_rst", ks_data, 0);
      if (m_lk) chk("lfsr", lfsr_state, m_lfsr());
    end
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ks_valid && n < 400);
    if (!ks_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  int n, k, cyc;
  logic [7:0]  hd;
  logic [79:0] hl;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; ks_ready = 1'b0; seed = '0;

    // Hand-derived pins on the model itself.
    gen(80'h1);
    chk("pin_b0", mbyte(0), 8'h80);
    chk("pin_b1", mbyte(8), 8'h00);
    chk("pin_tap0", mbyte(80), 8'h80);
    gen(80'h1 << 13);
    chk("pin_b1_13", mbyte(8), 8'h04);
    chk("pin_tap13", mbyte(80), 8'h80);
    gen(80'h1 << 62);
    chk("pin_tap62", mbyte(80), 8'h80);

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_data", ks_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", ks_valid, 0);
    chk("rst_lfsr", lfsr_state, 0);
    rst = 1'b0;

    // Zero seed: all bytes zero, full throughput.
    seed = '0; ks_ready = 1'b1;
    do_start();
    wait_valid(n);
    chk_i("lat_zero", 1 + n, WE + 10);
    chk("zero_b0", ks_data, 8'h00);
    for (int i = 1; i < 4; i++) begin
      wait_valid(n);
      chk_i("tput", n, 9);
      chk("zero_bn", ks_data, 8'h00);
    end
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;

    // Backpressure: HOLD freezes data and LFSR.
    seed = 80'hDEAD_BEEF_0123_4567_89AB; ks_ready = 1'b0;
    do_start();
    wait_valid(n);
    hd = m_d; hl = m_lfsr();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("hold_data", ks_data, hd);
      chk("hold_lfsr", lfsr_state, hl);
    end
    @(negedge clk); ks_ready = 1'b1;
    wait_valid(n);
    chk_i("accept_to_next", n, 9);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;

    // Abort mid warm-up (mid gather without warm-up), then a fresh run.
    seed = 80'h0123_4567_89AB_CDEF_1357;
    do_start();
    repeat ((WE > 0) ? 50 : 5) @(negedge clk);
    stop = 1'b1;
    @(posedge clk); #1;
    chk("stop_busy", busy, 0);
    chk("stop_valid", ks_valid, 0);
    @(negedge clk); stop = 1'b0;
    do_start();
    wait_valid(n);
    chk_i("lat_restart", 1 + n, WE + 10);
    for (k = 0; k < 4; k++) begin
      if (k > 0) wait_valid(n);
      chk("fresh_byte", ks_data, mbyte(WE + 8 * k));
    end

    // Reset at gather bit 4.
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstg_busy", busy, 0);
    chk("rstg_valid", ks_valid, 0);
    chk("rstg_data", ks_data, 8'h00);
    chk("rstg_lfsr", lfsr_state, 80'h0);
    @(negedge clk); rst = 1'b0;

    // start while busy is ignored; start+stop in GATHER goes idle.
    seed = 80'h5555_AAAA_0F0F_F0F0_3C3C;
    do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_valid(n);
    chk_i("lat_busy_start", 3 + n, WE + 10);
    repeat (3) @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    chk("ss_busy", busy, 0);
    @(negedge clk); start = 1'b0; stop = 1'b0;
    @(posedge clk); #1;
    chk("ss_stay_idle", busy, 0);

    // 64 bytes from the reference seed with random backpressure.
    seed = 80'hA5A5_1234_5678_9ABC_DEF0; ks_ready = 1'b1;
    do_start();
    wait_valid(n);
    chk_i("lat_ref", 1 + n, WE + 10);
    k = 0; cyc = 0;
    while (k < 64 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      ks_ready = ($urandom % 4) != 0;
      if (ks_valid && ks_ready) begin
        chk("ref_byte", ks_data, mbyte(WE + 8 * k));
        k++;
      end
    end
    chk_i("ref_count", k, 64);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;

    // Random control traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start    = ($urandom % 30) == 0;
      stop     = ($urandom % 150) == 0;
      ks_ready = ($urandom % 3) != 0;
      rst      = ($urandom % 700) == 0;
      seed     = 80'({$urandom, $urandom, $urandom});
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_ks_ctrl.md
LFSR_KS_CTRL -- requirements
Module: lfsr_ks_ctrl

Interface
REQ-001 The block SHALL have parameter WARMUP_CYCLES, default 160, giving the number of discarded shift cycles after seed load.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle request to load the seed and begin keystream generation.
REQ-005 The block SHALL have port stop, input, 1 bit: a one-cycle request to abort and return to idle.
REQ-006 The block SHALL have port seed, input, 80 bits: the LFSR initial value, sampled only in LOAD.
REQ-007 The block SHALL have port ks_data, output, 8 bits: the keystream byte.
REQ-008 The block SHALL have port ks_valid, output, 1 bit: ks_data is valid.
REQ-009 The block SHALL have port ks_ready, input, 1 bit: the consumer accepts ks_data.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port lfsr_state, output, 80 bits: the current LFSR parallel contents, for debug.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, WARMUP, GATHER and HOLD.
REQ-013 In IDLE, start=1 SHALL move the FSM to LOAD; otherwise it SHALL stay in IDLE.
REQ-014 LOAD SHALL last exactly one cycle, drive the LFSR Par_load=1 with seed, then move to WARMUP.
REQ-015 WARMUP SHALL drive shift_en=1 for exactly WARMUP_CYCLES cycles, ignore the serial bits, then move to GATHER.
REQ-016 GATHER SHALL drive shift_en=1 for exactly 8 cycles, shifting LFSR bit 0 (sampled before each shift) into the byte register MSB-first: byte <= {byte[6:0], bit0}; it SHALL then move to HOLD.
REQ-017 In HOLD, ks_valid SHALL be 1, ks_data SHALL be stable, and shift_en SHALL be 0.
REQ-018 In HOLD, ks_valid & ks_ready SHALL complete the transfer and move the FSM to GATHER on the next cycle.
REQ-019 In HOLD, ks_ready=0 SHALL keep the FSM in HOLD indefinitely with the LFSR frozen.
REQ-020 Latency: ks_valid SHALL first rise exactly WARMUP_CYCLES+10 cycles after the edge that samples start.
REQ-021 With ks_ready held high, throughput SHALL be one byte per 9 cycles.
REQ-022 stop=1 in any non-IDLE state SHALL move the FSM to IDLE on the next edge, drop ks_valid that same edge, and discard the partial byte.
REQ-023 When start and stop are asserted together, stop SHALL win outside IDLE and start SHALL win in IDLE.
REQ-024 start outside IDLE SHALL be ignored; there is no restart without passing through IDLE.
REQ-025 A bit counter (0..7) and a warm-up counter sized $clog2(WARMUP_CYCLES+1) SHALL both clear on entry to their state.
REQ-026 In IDLE, the LFSR SHALL hold its contents (shift_en=0, Par_load=0).

Reset
REQ-027 rst=1 SHALL force, on the next edge: the FSM to IDLE, ks_valid=0, ks_data=8'h00, busy=0, both counters to 0, and the LFSR cleared to 80'h0.
REQ-028 Reset SHALL take priority over start, stop and ks_ready in any state, including mid-WARMUP and mid-HOLD.

Configuration
REQ-029 When macro LFSR_KS_CTRL_WARMUP_EN is defined, the WARMUP state and its counter SHALL be built per REQ-015.
REQ-030 When LFSR_KS_CTRL_WARMUP_EN is undefined, LOAD SHALL go directly to GATHER, the warm-up counter SHALL not exist, and the REQ-020 latency SHALL be 10 cycles.

Structure
REQ-031 A shared package lfsr_ks_pkg SHALL hold the state enum type, LFSR width constant 80, byte width constant 8, and default WARMUP_CYCLES.
REQ-032 The block SHALL instantiate exactly one sub-module, the existing lfsr, driving its shift_en, Par_load and Seed, and using its Par_out as lfsr_state.

Verification
REQ-033 Test: seed=80'h0, start, ks_ready=1 -> every byte is 8'h00 and the first ks_valid appears at WARMUP_CYCLES+10 cycles (170 for the default).
REQ-034 Test: nonzero seed, ks_ready=0 for 20 cycles in HOLD -> ks_data and lfsr_state are unchanged; after ks_ready=1, the next byte arrives 9 cycles after acceptance.
REQ-035 Test: stop at warm-up cycle 50 -> next cycle is IDLE with busy=0 and ks_valid=0; a new start reloads the seed and the byte sequence matches a fresh run.
REQ-036 Test: rst pulsed mid-GATHER (bit 4) -> next cycle is IDLE, ks_data=8'h00, lfsr_state=80'h0.
REQ-037 Test: start pulsed while busy, and start+stop together in GATHER -> start is ignored, and stop wins (IDLE next cycle).
REQ-038 Test: reference-model comparison over 64 bytes for seed 80'hA5A5_1234_5678_9ABC_DEF0 in both macro builds -> bytes match the model, and latency is 170 (with WARMUP) or 10 (without).
